// File: rtl/phased_burst_if.sv
// Host-side bundle of the phased burst controller: burst request, phase-table writes,
// status and drive outputs, plus a debug view of the controller state.
interface phased_burst_if #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 10,
    parameter int BURST_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // start is a level request with no back-pressure: it takes effect only in IDLE with
    // burst_len != 0; cfg_we is a one-cycle write and cfg_ack pulses the cycle after acceptance.
    logic               start;
    logic [BURST_W-1:0] burst_len;
    logic               abort;
    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [PHASE_W-1:0] cfg_phase;
    logic               cfg_ack;
    logic               busy;
    logic               done;
    logic [NUM_CH-1:0]  ch_out;
    logic               fsm_state;

    modport master (
        output start, burst_len, abort, cfg_we, cfg_ch, cfg_phase,
        input  cfg_ack, busy, done, ch_out, fsm_state
    );

    modport slave (
        input  start, burst_len, abort, cfg_we, cfg_ch, cfg_phase,
        output cfg_ack, busy, done, ch_out, fsm_state
    );
endinterface

// File: rtl/phased_burst_controller.sv
// Emits burst_len square-wave periods on NUM_CH channels, each delayed by its phase-table entry.
// Define SHADOW_TABLE_EN to write a shadow table at any time and load it into the active table on start.
module phased_burst_controller #(
    parameter int NUM_CH      = 4,
    parameter int HALF_PERIOD = 337,
    parameter int PHASE_W     = 10,
    parameter int BURST_W     = 8
) (
    input logic           clk,
    input logic           rst,
    phased_burst_if.slave bus
);
    localparam int PERIOD = 2 * HALF_PERIOD;
    localparam int PC_W   = $clog2(PERIOD);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int T_W    = BURST_W + PHASE_W + 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    state_t             state_nx;
    logic               start_ok;
    logic               finish;
    logic [PC_W-1:0]    pc;
    logic [BURST_W-1:0] per;
    logic [BURST_W-1:0] len;
    logic [T_W-1:0]     t;
    logic [T_W-1:0]     span;
    logic [NUM_CH-1:0]  ch_nx;
    logic [NUM_CH-1:0]  ch_q;
    logic               done_q;
    logic               ack_q;
    logic               idx_ok;
    logic               wr_ok;
    logic [PHASE_W-1:0] phase_clamped;
    logic [PHASE_W-1:0] phase_tbl [NUM_CH];
`ifdef SHADOW_TABLE_EN
    logic [PHASE_W-1:0] shadow_tbl [NUM_CH];
`endif

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && (bus.burst_len != '0)) begin
                    state_nx = RUN;
                    start_ok = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if ((per == len) && (pc == PC_W'(PERIOD - 1))) begin
                    state_nx = IDLE;
                    finish   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign idx_ok        = ({1'b0, bus.cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign phase_clamped = (bus.cfg_phase > PHASE_W'(PERIOD - 1)) ? PHASE_W'(PERIOD - 1)
                                                                  : bus.cfg_phase;
`ifdef SHADOW_TABLE_EN
    assign wr_ok = bus.cfg_we && idx_ok;
`else
    assign wr_ok = bus.cfg_we && idx_ok && (state == IDLE);
`endif

    // (t - ph) mod PERIOD comes from pc with a single wrap because every ph is below PERIOD.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [T_W-1:0] ph_ext;
        logic [T_W-1:0] pc_ext;
        logic [T_W-1:0] local_t;
        assign ph_ext  = T_W'(phase_tbl[g]);
        assign pc_ext  = T_W'(pc);
        assign local_t = (pc_ext >= ph_ext) ? (pc_ext - ph_ext)
                                            : (pc_ext + T_W'(PERIOD) - ph_ext);
        assign ch_nx[g] = (state == RUN) && (t >= ph_ext) && (t < ph_ext + span)
                          && (local_t < T_W'(HALF_PERIOD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            per    <= '0;
            len    <= '0;
            t      <= '0;
            span   <= '0;
            ch_q   <= '0;
            done_q <= 1'b0;
            ack_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                phase_tbl[i] <= '0;
`ifdef SHADOW_TABLE_EN
                shadow_tbl[i] <= '0;
`endif
            end
        end else begin
            state  <= state_nx;
            done_q <= finish;
            ack_q  <= wr_ok;
            ch_q   <= ((state == RUN) && (state_nx == RUN)) ? ch_nx : '0;
            if (start_ok) begin
                len  <= bus.burst_len;
                span <= T_W'(bus.burst_len) * T_W'(PERIOD);
                pc   <= '0;
                per  <= '0;
                t    <= '0;
            end else if (state == RUN) begin
                t <= t + 1'b1;
                if (pc == PC_W'(PERIOD - 1)) begin
                    pc  <= '0;
                    per <= per + 1'b1;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
`ifdef SHADOW_TABLE_EN
            if (wr_ok) shadow_tbl[bus.cfg_ch] <= phase_clamped;
            if (start_ok) phase_tbl <= shadow_tbl;
`else
            if (wr_ok) phase_tbl[bus.cfg_ch] <= phase_clamped;
`endif
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.cfg_ack   = ack_q;
    assign bus.ch_out    = ch_q;
    assign bus.fsm_state = (state == RUN);
endmodule

// File: tb/tb_phased_burst_controller.sv
// Scoreboard bench for phased_burst_controller with PERIOD=8; NUM_CH=3 so that an
// out-of-range cfg_ch (3) is representable on the 2-bit index.
module tb_phased_burst_controller;
    localparam int NUM_CH      = 3;
    localparam int HALF_PERIOD = 4;
    localparam int PERIOD      = 2 * HALF_PERIOD;
    localparam int PHASE_W     = 10;
    localparam int BURST_W     = 8;
    localparam int CH_W        = 2;
    localparam int VEC_W       = NUM_CH + 3;
`ifdef SHADOW_TABLE_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_ph [NUM_CH];
    logic [VEC_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    phased_burst_if #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .BURST_W(BURST_W)) bus ();

    phased_burst_controller #(
        .NUM_CH(NUM_CH), .HALF_PERIOD(HALF_PERIOD), .PHASE_W(PHASE_W), .BURST_W(BURST_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {cfg_ack, busy, done, ch_out}
    function automatic logic [VEC_W-1:0] observe();
        return {bus.cfg_ack, bus.busy, bus.done, bus.ch_out};
    endfunction

    function automatic logic [NUM_CH-1:0] ref_ch(input int t, input int len);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++)
            v[i] = (t >= exp_ph[i]) && (t < exp_ph[i] + len * PERIOD)
                   && (((t - exp_ph[i]) % PERIOD) < HALF_PERIOD);
        return v;
    endfunction

    task automatic cfg_write(input int ch, input int ph, input logic exp_ack, input string tag);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_phase = PHASE_W'(ph);
        tick();
        bus.cfg_we = 1'b0;
        check(tag, 32'(bus.cfg_ack), 32'(exp_ack));
        tick();
        check({tag, "_pulse"}, 32'(bus.cfg_ack), 32'd0);
    endtask

    // Starts a burst; optional abort, mid-run start and mid-run write at the given sample index.
    task automatic run_burst(input int len, input int abort_at, input int start_at,
                             input int wr_at, input int wr_ch, input int wr_ph, input string tag);
        int total;
        int n;
        logic [NUM_CH-1:0] c;
        logic b, d, a;
        logic [VEC_W-1:0] exp_v;
        total = (len + 1) * PERIOD;
        n = (abort_at >= 0) ? abort_at + 3 : total + 2;
        for (int k = 1; k <= n; k++) begin
            c = '0;
            b = 1'b0;
            d = 1'b0;
            a = (wr_at >= 0 && k == wr_at + 1) ? SHADOW : 1'b0;
            if (abort_at >= 0) begin
                if (k <= abort_at + 1) begin
                    b = 1'b1;
                    if (k >= 2) c = ref_ch(k - 2, len);
                end
            end else if (k <= total) begin
                b = 1'b1;
                if (k >= 2) c = ref_ch(k - 2, len);
            end else if (k == total + 1) begin
                d = 1'b1;
            end
            exp_q.push_back({a, b, d, c});
        end
        bus.start     = 1'b1;
        bus.burst_len = BURST_W'(len);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            exp_v = exp_q.pop_front();
            check($sformatf("%s_k%0d", tag, k), 32'(observe()), 32'(exp_v));
            bus.abort = (abort_at >= 0 && k == abort_at + 1);
            bus.start = (start_at >= 0 && k == start_at);
            if (bus.start) bus.burst_len = BURST_W'(len + 2);
            bus.cfg_we    = (wr_at >= 0 && k == wr_at);
            bus.cfg_ch    = CH_W'(wr_ch);
            bus.cfg_phase = PHASE_W'(wr_ph);
            tick();
        end
        bus.abort  = 1'b0;
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.burst_len = '0;
        bus.abort     = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_phase = '0;
        for (int i = 0; i < NUM_CH; i++) exp_ph[i] = 0;
        repeat (3) tick();
        check("reset_vec", 32'(observe()), 32'd0);
        check("reset_state", 32'(bus.fsm_state), 32'd0);
        rst = 1'b0;
        tick();

        // in-phase channels
        run_burst(2, -1, -1, -1, 0, 0, "aligned");

        // ch1 lags ch0 by two cycles
        cfg_write(1, 2, 1'b1, "wr_ch1");
        exp_ph[1] = 2;
        run_burst(1, -1, -1, -1, 0, 0, "lag2");

        // clamping to PERIOD-1 and out-of-range index
        cfg_write(0, 9, 1'b1, "wr_clamp9");
        exp_ph[0] = 7;
        cfg_write(2, 8, 1'b1, "wr_clamp8");
        exp_ph[2] = 7;
        cfg_write(3, 5, 1'b0, "wr_badch");
        run_burst(1, -1, -1, -1, 0, 0, "clamped");

        // abort during RUN, then a fresh burst
        run_burst(3, 5, -1, -1, 0, 0, "abort");
        run_burst(1, -1, -1, -1, 0, 0, "after_abort");

        // zero-length start is ignored
        bus.start     = 1'b1;
        bus.burst_len = '0;
        for (int k = 0; k < 4; k++) exp_q.push_back('0);
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.start = 1'b0;
            check($sformatf("len0_k%0d", k), 32'(observe()), 32'(exp_q.pop_front()));
        end

        // start during RUN is ignored
        run_burst(2, -1, 3, -1, 0, 0, "restart");

        // write during RUN: never alters the running burst
        run_burst(1, -1, -1, 4, 1, 3, "midwr");
        if (SHADOW) exp_ph[1] = 3;
        run_burst(1, -1, -1, -1, 0, 0, "post_midwr");

        // reset mid-burst clears outputs and the table, no done
        bus.start     = 1'b1;
        bus.burst_len = BURST_W'(2);
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_vec", 32'(observe()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst_mid_idle%0d", k), 32'(observe()), 32'd0);
        end
        for (int i = 0; i < NUM_CH; i++) exp_ph[i] = 0;
        run_burst(1, -1, -1, -1, 0, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
